// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
// Generic pipeline stage register with a valid/ready handshake, an external
// stall and an optional skid entry. With the skid entry enabled, in_ready is
// driven from state only, which cuts the combinational ready path through
// the stage. The control field is squashed on flush, while the data field
// keeps its value. A saturating counter records the back-pressured cycles.
module pipe_stage_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 16,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy encoding: bit 0 = main entry valid, bit 1 = skid entry valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic              in_fire;
    logic              out_fire;
    logic              ld_main_in;
    logic              ld_main_skid;
    logic              ld_skid;
    logic              bp_cycle;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] one;
        one = {{(CNT_W-1){1'b0}}, 1'b1};
        return (&v) ? v : v + one;
    endfunction

    assign main_v   = state[0];
    assign skid_v   = state[1];
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_v & out_ready & ~stall;
    // A back-pressured cycle: something to deliver, but it cannot leave.
    assign bp_cycle = main_v & (stall | ~out_ready) & ~flush;

    // Occupancy register; reset and flush both empty the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next occupancy and which payload slots load this cycle.
    always_comb begin
        state_nxt    = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt  = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        // Only reachable with the skid entry: the single-entry
                        // in_ready already implies out_fire when main is full.
                        state_nxt = FULL;
                        ld_skid   = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt    = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Payload storage: flush zeroes control only, data keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else if (flush) begin
            main_ctrl <= '0;
            skid_ctrl <= '0;
        end else begin
            if (ld_main_in) begin
                main_data <= in_data;
                main_ctrl <= in_ctrl;
            end else if (ld_main_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (ld_skid) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
            end
        end
    end

    // Back-pressure counter, saturating, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bp_cycle) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // Outputs; stale control is masked whenever the main entry is empty.
    always_comb begin
        out_valid = main_v;
        out_data  = main_data;
        out_ctrl  = main_v ? main_ctrl : '0;
        if (SKID_EN != 0) begin
            in_ready = ~skid_v & ~stall;
        end else begin
            in_ready = (~main_v | out_ready) & ~stall;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: one skid instance and one single-entry
// instance share stimulus; each is compared with a FIFO-occupancy model.
module tb_pipe_stage_skid_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic        out_ready = 1'b0;

    logic        s_in_ready, s_out_valid, n_in_ready, n_out_valid;
    logic [31:0] s_out_data, n_out_data;
    logic [15:0] s_out_ctrl, n_out_ctrl;
    logic [3:0]  s_cnt, n_cnt;

    int total = 0;
    int bad   = 0;

    // Model: per instance (0 = skid, 1 = single) a FIFO of {data,ctrl}.
    logic [47:0] mq [2][2];
    int          mc [2];
    logic [31:0] mdata [2];
    int          mcnt [2];

    always #5 clk = ~clk;

    pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_ctrl(s_out_ctrl), .stall_cnt(s_cnt));

    pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(16), .SKID_EN(0), .CNT_W(4)) u_one (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(n_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
        .out_ctrl(n_out_ctrl), .stall_cnt(n_cnt));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_rdy(input int m);
        if (stall) return 1'b0;
        if (m == 0) return mc[m] < 2;
        return (mc[m] == 0) || out_ready;
    endfunction

    function automatic logic obs_rdy(input int m);
        return (m == 0) ? s_in_ready : n_in_ready;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mc[m] = 0; mdata[m] = '0; mcnt[m] = 0;
        end
    endtask

    task automatic model_edge(input int m, input logic ifire, input logic [47:0] pl);
        logic ofire;
        if (flush) begin
            mc[m] = 0;
        end else begin
            if (mc[m] > 0 && (stall || !out_ready) && mcnt[m] < 15) mcnt[m]++;
            ofire = (mc[m] > 0) && out_ready && !stall;
            if (ofire) begin
                mq[m][0] = mq[m][1];
                mc[m]--;
            end
            if (ifire) begin
                mq[m][mc[m]] = pl;
                mc[m]++;
            end
            if (mc[m] > 0) mdata[m] = mq[m][0][47:16];
        end
    endtask

    task automatic check_outs();
        logic [15:0] ec;
        for (int m = 0; m < 2; m++) begin
            ec = (mc[m] > 0) ? mq[m][0][15:0] : 16'h0;
            chk($sformatf("valid%0d", m), (m == 0) ? s_out_valid : n_out_valid, mc[m] > 0);
            chk($sformatf("data%0d", m),  (m == 0) ? s_out_data : n_out_data, mdata[m]);
            chk($sformatf("ctrl%0d", m),  (m == 0) ? s_out_ctrl : n_out_ctrl, ec);
            chk($sformatf("cnt%0d", m),   (m == 0) ? s_cnt : n_cnt, mcnt[m]);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic cyc(input logic iv, input logic [31:0] d, input logic [15:0] c,
                       input logic ordy, input logic st, input logic fl);
        logic rf [2];
        in_valid = iv; in_data = d; in_ctrl = c;
        out_ready = ordy; stall = st; flush = fl;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rdy%0d", m), obs_rdy(m), m_rdy(m));
            rf[m] = iv && m_rdy(m);
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) model_edge(m, rf[m], {d, c});
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_ctrl = 16'hFFFF;
        out_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst_rdy_s", s_in_ready, 1'b1);
        chk("rst_rdy_n", n_in_ready, 1'b1);
    endtask

    initial begin
        model_reset();
        // Reset with a payload presented
        do_reset();

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, i, 16'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_s", s_out_data, i);
            chk("stream_n", n_out_data, i);
        end
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);

        // Skid: A in main, B lands in skid as out_ready drops, C waits
        cyc(1'b1, 32'hA, 16'h1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 16'h2, 1'b0, 1'b0, 1'b0);
        chk("skid_full_rdy", s_in_ready, 1'b0);
        chk("skid_hold_a", s_out_data, 32'hA);
        cyc(1'b1, 32'hC, 16'h3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 16'h3, 1'b1, 1'b0, 1'b0);
        chk("skid_b", s_out_data, 32'hB);
        cyc(1'b1, 32'hC, 16'h3, 1'b1, 1'b0, 1'b0);
        chk("skid_c", s_out_data, 32'hC);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("skid_drained", s_out_valid, 1'b0);

        // Flush while full, with a payload presented in the same cycle
        cyc(1'b1, 32'h11, 16'h00FF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22, 16'h00FF, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33, 16'h00FF, 1'b0, 1'b0, 1'b1);
        chk("flush_valid", s_out_valid, 1'b0);
        chk("flush_ctrl", s_out_ctrl, 16'h0);
        chk("flush_data", s_out_data, 32'h11);
        cyc(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        chk("flush_drop", s_out_valid, 1'b0);

        // Stall for 5 cycles with out_ready high
        do_reset();
        cyc(1'b1, 32'h50, 16'h5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h51, 16'h6, 1'b1, 1'b1, 1'b0);
            chk("stall_frozen", s_out_data, 32'h50);
        end
        chk("stall_cnt_s", s_cnt, 4'd5);
        chk("stall_cnt_n", n_cnt, 4'd5);
        cyc(1'b1, 32'h51, 16'h6, 1'b1, 1'b0, 1'b0);
        chk("stall_resume", s_out_data, 32'h51);

        // Saturation over 20 back-pressured cycles
        for (int i = 0; i < 20; i++) cyc(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        chk("sat_s", s_cnt, 4'd15);
        chk("sat_n", n_cnt, 4'd15);

        // Asynchronous reset between clock edges
        cyc(1'b1, 32'h77, 16'h7, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0), $urandom, 16'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 19) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
